// File: rtl/alu_seq_top_if.sv
// Command/result handshake bundle for alu_seq_top: a valid/ready command port in,
// a valid/ready result port out.
interface alu_seq_top_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             flag;
    logic             carry;
    logic             neg;

    modport master (
        output in_valid, op, acc_sel, a, b, out_ready,
        input  in_ready, out_valid, R, flag, carry, neg
    );

    modport slave (
        input  in_valid, op, acc_sel, a, b, out_ready,
        output in_ready, out_valid, R, flag, carry, neg
    );
endinterface

// File: rtl/alu_seq_top.sv
// Handshaked ALU: single-cycle logic/arithmetic ops, bit-serial rotates, registered
// result with zero/carry/sign flags and an accumulator usable as operand A.
module alu_seq_top #(
    parameter int WIDTH = 7,
    parameter int SHW   = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_top_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ROT,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_NAND = 3'b000,
        OP_ROL  = 3'b001,
        OP_ROR  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_XOR  = 3'b101,
        OP_AND  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             flag_q, flag_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic [WIDTH-1:0] rot_r;
    logic             rot_c;
    logic             is_rot;
    logic [SHW-1:0]   shamt;
    logic             load;
    logic [WIDTH-1:0] res_r;
    logic             res_c;

    assign is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);
    assign shamt  = b_q[SHW-1:0];

    // Single-cycle datapath; rotates with a zero amount fall through as PASS.
    always_comb begin
        sum   = '0;
        alu_r = work_q;
        alu_c = 1'b0;
        case (op_q)
            OP_NAND: alu_r = ~(work_q & b_q);
            OP_ADD: begin
                sum   = {1'b0, work_q} + {1'b0, b_q};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
            end
            OP_SUB: begin
                sum   = {1'b0, work_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
            end
            OP_XOR:  alu_r = work_q ^ b_q;
            OP_AND:  alu_r = work_q & b_q;
            default: alu_r = work_q;
        endcase
    end

    // One rotate step; the carry is the bit that wraps around.
    always_comb begin
        if (op_q == OP_ROR) begin
            rot_r = {work_q[0], work_q[WIDTH-1:1]};
            rot_c = work_q[0];
        end else begin
            rot_r = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            rot_c = work_q[WIDTH-1];
        end
    end

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        b_d     = b_q;
        count_d = count_q;
        r_d     = r_q;
        acc_d   = acc_q;
        flag_d  = flag_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        load    = 1'b0;
        res_r   = alu_r;
        res_c   = alu_c;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = op_e'(bus.op);
                    work_d  = bus.acc_sel ? acc_q : bus.a;
                    b_d     = bus.b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_rot && (shamt != '0)) begin
                    count_d = shamt;
                    state_d = S_ROT;
                end else begin
                    load = 1'b1;
                end
            end
            S_ROT: begin
                work_d  = rot_r;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    load  = 1'b1;
                    res_r = rot_r;
                    res_c = rot_c;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Result, flags and accumulator are captured together on entry to DONE.
        if (load) begin
            state_d = S_DONE;
            r_d     = res_r;
            flag_d  = (res_r == '0);
            carry_d = res_c;
            neg_d   = res_r[WIDTH-1];
            acc_d   = res_r;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NAND;
            work_q  <= '0;
            b_q     <= '0;
            count_q <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            b_q     <= b_d;
            count_q <= count_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            flag_q  <= flag_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = rst && (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.R         = r_q;
    assign bus.flag      = flag_q;
    assign bus.carry     = carry_q;
    assign bus.neg       = neg_q;
endmodule

// File: tb/tb_alu_seq_top.sv
// Scoreboard bench for alu_seq_top: expected results are queued at acceptance and
// compared, with latency, when out_valid rises.
module tb_alu_seq_top;
    localparam int W   = 7;
    localparam int SHW = 3;

    localparam logic [2:0] NAND = 3'b000, ROL = 3'b001, ROR = 3'b010, ADD = 3'b011;
    localparam logic [2:0] SUB  = 3'b100, XOR = 3'b101, AND = 3'b110, PASS = 3'b111;

    typedef struct packed {
        logic [W-1:0] r;
        logic         flag;
        logic         carry;
        logic         neg;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_top_if #(.WIDTH(W)) bus ();
    alu_seq_top #(.WIDTH(W), .SHW(SHW)) dut (.clk(clk), .rst(rst), .bus(bus));

    res_t         sb[$];
    logic [W-1:0] acc_m = '0;
    int           total = 0;
    int           bad   = 0;

    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         x;
        logic [W-1:0] r;
        logic         c;
        int           n;
        int           s;
        r = '0;
        c = 1'b0;
        n = int'(b[SHW-1:0]);
        case (op)
            NAND: r = ~(a & b);
            ROL: begin
                r = a;
                for (int i = 0; i < n; i++) begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
            end
            ROR: begin
                r = a;
                for (int i = 0; i < n; i++) begin c = r[0]; r = {r[0], r[W-1:1]}; end
            end
            ADD: begin s = int'(a) + int'(b); r = W'(s); c = (s >= (1 << W)); end
            SUB: begin s = int'(a) - int'(b); r = W'(s); c = (a >= b); end
            XOR: r = a ^ b;
            AND: r = a & b;
            default: r = a;
        endcase
        x.r = r; x.flag = (r == '0); x.carry = c; x.neg = r[W-1];
        return x;
    endfunction

    task automatic send(input logic [2:0] op, input logic sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input res_t e);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
        if (!bus.in_ready) begin
            $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
            $fatal(1, "in_ready never rose");
        end
        bus.in_valid = 1'b1; bus.op = op; bus.acc_sel = sel; bus.a = a; bus.b = b;
        @(posedge clk);
        sb.push_back(e);
        acc_m = e.r;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin @(negedge clk); lat++; end
        if (!bus.out_valid) begin
            $display("FAIL result_timeout: out_valid=%b want 1", bus.out_valid);
            $fatal(1, "out_valid never rose");
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.R, bus.flag, bus.carry, bus.neg} !== '0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b R=%b f=%b c=%b n=%b want all 0",
                     bus.in_ready, bus.out_valid, bus.R, bus.flag, bus.carry, bus.neg);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release: in_ready=%b want 1", bus.in_ready);
        end
    endtask

    task automatic test_nand();
        res_t e, got;
        int   lat;
        bus.out_ready = 1'b1;
        send(NAND, 1'b0, 7'b1010101, 7'b1100110, {7'b0111011, 1'b0, 1'b0, 1'b0});
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (lat !== 1) begin bad++; $display("FAIL nand_lat: got %0d want 1", lat); end
        total++; if (got !== e) begin bad++; $display("FAIL nand_res: got %b want %b", got, e); end
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++; $display("FAIL nand_pulse: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rotate();
        res_t e, got;
        int   lat;
        logic [2:0]   ops [4]  = '{ROL, ROR, ROR, ROL};
        logic [W-1:0] as  [4]  = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0000011};
        logic [W-1:0] bs  [4]  = '{7'd3, 7'd0, 7'd1, 7'd7};
        res_t         es  [4]  = '{{7'b0001100, 1'b0, 1'b0, 1'b0}, {7'b0000001, 1'b0, 1'b0, 1'b0},
                                   {7'b1000000, 1'b0, 1'b1, 1'b1}, {7'b0000011, 1'b0, 1'b1, 1'b0}};
        int           lats[4]  = '{4, 1, 2, 8};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], 1'b0, as[i], bs[i], es[i]);
            wait_out(lat);
            e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
            total++;
            if (lat !== lats[i]) begin bad++; $display("FAIL rot%0d_lat: got %0d want %0d", i, lat, lats[i]); end
            total++;
            if (got !== e) begin bad++; $display("FAIL rot%0d_res: got %b want %b", i, got, e); end
            consume();
        end
    endtask

    task automatic test_add_sub();
        res_t e, got;
        int   lat;
        logic [2:0]   ops [3] = '{ADD, SUB, SUB};
        logic [W-1:0] as  [3] = '{7'b1111111, 7'b0000101, 7'b0000101};
        logic [W-1:0] bs  [3] = '{7'b0000001, 7'b0000110, 7'b0000101};
        res_t         es  [3] = '{{7'b0000000, 1'b1, 1'b1, 1'b0}, {7'b1111111, 1'b0, 1'b0, 1'b1},
                                  {7'b0000000, 1'b1, 1'b1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 1'b0, as[i], bs[i], es[i]);
            wait_out(lat);
            e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
            total++;
            if (got !== e) begin bad++; $display("FAIL arith%0d_res: got %b want %b", i, got, e); end
            consume();
        end
    endtask

    task automatic test_acc_chain();
        res_t e, got;
        int   lat;
        send(PASS, 1'b0, 7'b0000101, 7'b0110011, {7'b0000101, 1'b0, 1'b0, 1'b0});
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (got !== e) begin bad++; $display("FAIL chain_pass: got %b want %b", got, e); end
        consume();
        send(ADD, 1'b1, 7'b1111111, 7'b0000011, {7'b0001000, 1'b0, 1'b0, 1'b0});
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (got !== e) begin bad++; $display("FAIL chain_add: got %b want %b", got, e); end
        consume();
    endtask

    task automatic test_backpressure();
        res_t e, got, ey;
        int   lat;
        send(XOR, 1'b0, 7'b0101010, 7'b1111111, {7'b1010101, 1'b0, 1'b0, 1'b1});
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (got !== e) begin bad++; $display("FAIL bp_first: got %b want %b", got, e); end
        ey = {7'b0000101, 1'b0, 1'b0, 1'b0};
        bus.in_valid = 1'b1; bus.op = ADD; bus.acc_sel = 1'b0; bus.a = 7'd2; bus.b = 7'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = {bus.R, bus.flag, bus.carry, bus.neg};
            total++;
            if ({bus.out_valid, bus.in_ready, got} !== {1'b1, 1'b0, e}) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%b want 1 0 %b",
                         i, bus.out_valid, bus.in_ready, got, e);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        @(posedge clk);
        sb.push_back(ey);
        acc_m = ey.r;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept: in_ready=%b want 0", bus.in_ready); end
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (lat !== 1) begin bad++; $display("FAIL bp_next_lat: got %0d want 1", lat); end
        total++; if (got !== e) begin bad++; $display("FAIL bp_next_res: got %b want %b", got, e); end
        consume();
    endtask

    task automatic test_reset_mid_rot();
        res_t e, got;
        int   lat;
        int   seen;
        send(ROL, 1'b0, 7'b1010011, 7'd6, model(ROL, 7'b1010011, 7'd6));
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rr_busy: out_valid=%b want 0", bus.out_valid); end
        rst = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.in_ready, bus.R, bus.flag, bus.carry, bus.neg} !== '0) begin
            bad++;
            $display("FAIL rr_clear: vld=%b rdy=%b R=%b f=%b c=%b n=%b want all 0",
                     bus.out_valid, bus.in_ready, bus.R, bus.flag, bus.carry, bus.neg);
        end
        sb.delete();
        acc_m = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rr_ready: in_ready=%b want 1", bus.in_ready); end
        seen = 0;
        repeat (8) begin @(negedge clk); if (bus.out_valid !== 1'b0) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rr_spurious: out_valid cycles=%0d want 0", seen); end
        send(ADD, 1'b1, 7'b1111111, 7'b0000010, {7'b0000010, 1'b0, 1'b0, 1'b0});
        wait_out(lat);
        e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
        total++; if (got !== e) begin bad++; $display("FAIL rr_acc: got %b want %b", got, e); end
        consume();
    endtask

    task automatic test_back_to_back();
        res_t         e, got;
        int           lat, want_lat;
        logic [2:0]   op;
        logic         sel;
        logic [W-1:0] a, b;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = 1'($urandom_range(0, 1));
            a   = W'($urandom);
            b   = W'($urandom);
            want_lat = ((op == ROL || op == ROR) && b[SHW-1:0] != '0) ? 1 + int'(b[SHW-1:0]) : 1;
            send(op, sel, a, b, model(op, sel ? acc_m : a, b));
            wait_out(lat);
            e = sb.pop_front(); got = {bus.R, bus.flag, bus.carry, bus.neg};
            total++;
            if (lat !== want_lat) begin
                bad++; $display("FAIL b2b%0d_lat: op=%b got %0d want %0d", i, op, lat, want_lat);
            end
            total++;
            if (got !== e) begin
                bad++; $display("FAIL b2b%0d_res: op=%b sel=%b a=%b b=%b got %b want %b", i, op, sel, a, b, got, e);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.acc_sel   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_nand();
        test_rotate();
        test_add_sub();
        test_acc_chain();
        test_backpressure();
        test_reset_mid_rot();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
